// File: rtl/lab3_z1_sdiv_32s_16s_seq_if.sv
// Start/ready/done handshake and operand/result bus of the sequential
// 32s/16s signed divider.
interface lab3_z1_sdiv_32s_16s_seq_if;
    logic        ce;
    logic        start;
    logic [31:0] din0;
    logic [15:0] din1;
    logic        ready;
    logic        done;
    logic [31:0] quot;
    logic [15:0] rem;
    logic        dbz;

    modport master (
        output ce, start, din0, din1,
        input  ready, done, quot, rem, dbz
    );

    modport slave (
        input  ce, start, din0, din1,
        output ready, done, quot, rem, dbz
    );
endinterface

// File: rtl/lab3_z1_sdiv_32s_16s_seq.sv
// Sequential signed divider, 32-bit dividend by 16-bit divisor.
// Radix-2 restoring division on magnitudes, then a sign fix-up step.
// C semantics: quotient truncates toward zero, remainder takes the
// dividend's sign. Divide-by-zero runs the full latency and flags dbz.
module lab3_z1_sdiv_32s_16s_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    lab3_z1_sdiv_32s_16s_seq_if.slave  div_if
);

    // Only the 32/16/32 configuration is implemented.
    if (ID < 0 || din0_WIDTH != 32 || din1_WIDTH != 16 || dout_WIDTH != 32) begin : g_bad_cfg
        $error("lab3_z1_sdiv_32s_16s_seq: unsupported width configuration");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;     // iterations 0..31, value 32 = one alignment slot
    logic [31:0] dvd_q,   dvd_d;     // dividend magnitude shifting out, quotient shifting in
    logic [15:0] prem_q,  prem_d;    // partial remainder (always < divisor magnitude)
    logic [15:0] dvs_q,   dvs_d;     // divisor magnitude
    logic        sq_q,    sq_d;      // quotient sign
    logic        sr_q,    sr_d;      // remainder sign
    logic        dbzn_q,  dbzn_d;    // divisor was zero
    logic [15:0] lo_q,    lo_d;      // raw dividend[15:0], returned as rem on divide-by-zero
    logic [31:0] quot_q,  quot_d;
    logic [15:0] rem_q,   rem_d;
    logic        dbz_q,   dbz_d;

    logic [31:0] a_mag;
    logic [15:0] b_mag;
    logic [16:0] shifted;
    logic [15:0] diff;
    logic        take;

    // Operand magnitudes; |-2^31| = 2^31 is exact as a 32-bit unsigned value.
    assign a_mag = div_if.din0[31] ? (~div_if.din0 + 32'd1) : div_if.din0;
    assign b_mag = div_if.din1[15] ? (~div_if.din1 + 16'd1) : div_if.din1;

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    assign shifted = {prem_q, dvd_q[31]};
    assign take    = (shifted >= {1'b0, dvs_q});
    assign diff    = shifted[15:0] - dvs_q;

    // Next-state logic; with ce low every register holds its value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        prem_d  = prem_q;
        dvs_d   = dvs_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        dbzn_d  = dbzn_q;
        lo_d    = lo_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        if (div_if.ce) begin
            case (state_q)
                S_IDLE: begin
                    if (div_if.start) begin
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        sq_d    = div_if.din0[31] ^ div_if.din1[15];
                        sr_d    = div_if.din0[31];
                        dbzn_d  = (div_if.din1 == 16'd0);
                        lo_d    = div_if.din0[15:0];
                        prem_d  = 16'd0;
                        cnt_d   = 6'd0;
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    // 32 iterations, then one slot so the result edge lands
                    // 34 enabled edges after acceptance.
                    if (!cnt_q[5]) begin
                        prem_d = take ? diff : shifted[15:0];
                        dvd_d  = {dvd_q[30:0], take};
                        cnt_d  = cnt_q + 6'd1;
                    end else begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    if (dbzn_q) begin
                        quot_d = 32'hFFFF_FFFF;
                        rem_d  = lo_q;
                        dbz_d  = 1'b1;
                    end else begin
                        quot_d = sq_q ? (~dvd_q + 32'd1) : dvd_q;
                        rem_d  = sr_q ? (~prem_q + 16'd1) : prem_q;
                        dbz_d  = 1'b0;
                    end
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers; async reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            dvd_q   <= 32'd0;
            prem_q  <= 16'd0;
            dvs_q   <= 16'd0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            dbzn_q  <= 1'b0;
            lo_q    <= 16'd0;
            quot_q  <= 32'd0;
            rem_q   <= 16'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            prem_q  <= prem_d;
            dvs_q   <= dvs_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            dbzn_q  <= dbzn_d;
            lo_q    <= lo_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign div_if.ready = (state_q == S_IDLE);
    assign div_if.done  = (state_q == S_DONE);
    assign div_if.quot  = quot_q;
    assign div_if.rem   = rem_q;
    assign div_if.dbz   = dbz_q;

endmodule
